me_core: RTL and testbench
==========================

# me_core

Full-search block-matching motion-estimation core for the 4K/60 ME datapath. It compares one 8×8 current block against a 23×23-pixel search window (horizontal and vertical displacements 0..15). The window is streamed in one 23-pixel reference row per clock. After all 23 rows it reports the minimum SAD and its motion vector. An upstream feeder sits in front of it and supplies the current-block rows and the reference rows in lock-step.

## Interface
- Parameters: none. All sizes are fixed constants in `me_core_pkg`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `crt_frame_0`..`crt_frame_15` in 64 each: current-block row fed to PE k (vertical offset k). Pixel 0 is in bits [63:56], pixel 7 in [7:0], unsigned 8-bit.
- `pre_frame_0`..`pre_frame_15` in 64 each: 8-pixel slices of the current reference row, where `pre_frame_x` = row pixels x..x+7.
  - Pixel x sits in bits [63:56]; same byte order as the current rows.
  - The feeder derives them from one 23-byte row, with pixel 0 in the MSB byte.
- `sad_min` out 14: minimum 8×8 SAD of the last completed search.
- `motion_vec_x_min` out 4: horizontal displacement of that minimum.
- `motion_vec_y_min` out 4: vertical displacement of that minimum.

## Operation
- A 5-bit row counter `r` runs 0..22 and then wraps to 0; each wrap starts a new search with no idle cycles.
- On every clock, PE k (k = 0..15) decides whether to accumulate:
  - Its row is valid iff k ≤ r ≤ k+7. The feeder must present current-block row (r−k) on `crt_frame_k` in that cycle; otherwise `crt_frame_k` is don't-care.
  - When valid, for each x = 0..15: acc[k][x] += Σ over i=0..7 of |crt_frame_k.pix[i] − pre_frame_x.pix[i]|.
  - At PE k's first valid row (r == k) the accumulator loads the sum instead of adding, so no separate clear is needed.
- Arithmetic rules:
  - All values are unsigned.
  - Absolute difference is taken at 9 bits.
  - A row sum is 11 bits.
  - The accumulator is 14 bits; the maximum value is 64×255 = 16320, so no overflow is possible.
- Minimum selection happens in the cycle after the edge where r = 22 is accumulated, i.e. in the r = 0 cycle of the next search:
  - A comparator tree scans all 256 acc[y][x] values in y-major, then x, order.
  - Strict less-than comparison, so on a tie the lowest y wins, then the lowest x.
  - The result is registered into the three outputs.
- Outputs hold their value until the next search completes.
- Reset (asserted at any time, including mid-search):
  - r = 0 and every accumulator = 0.
  - `sad_min` = 14'h3FFF, `motion_vec_x_min` = 0, `motion_vec_y_min` = 0.
- After reset is released, the first rising edge samples reference row 0.

## Timing
- One reference row is consumed per cycle; one search takes exactly 23 cycles.
- Latency: outputs change on the 24th rising edge after reset release (row 22 is sampled on edge 23, the result is registered on edge 24).
- Every later result appears 23 cycles after the previous one.
- No handshake: the feeder must supply a row every cycle while reset is deasserted.
- Reset mid-search discards the partial search. The previous outputs are also cleared to their reset values.

## Configuration
- Macro `ME_CORE_DONE_EN`.
- Defined: adds an output port `done` (1 bit), reset value 0. It is high for exactly the one cycle in which the three result outputs have just updated.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `me_core_pkg` holds the shared constants: PIX_W=8, BLK=8, RANGE=16, WIN=23, SAD_W=14.
- The package also holds a `pixel_row_t` typedef (8×8-bit packed row).
- Sub-module `me_core_pe`:
  - One per vertical offset, instantiated 16× via generate.
  - Contains 16 row-SAD units and 16 accumulators, with its k index as a port or parameter.
- The top level contains the row counter, the valid masks, the 256-way minimum tree and the output registers.

## Test plan
- All `crt_frame_*` = 0. Every row is 23 bytes of zeros except the last byte = 1, so `pre_frame_15` = 64'h1 and the others are 0.
  - Required: `sad_min` = 0, `motion_vec_x_min` = 0, `motion_vec_y_min` = 0 on edge 24.
- Window of zeros with an 8×8 patch of value 200 at (x=5, y=9); the current block is all 200 (feeder skews rows per PE).
  - Required: `sad_min` = 0, vector (5, 9).
- Current block all 10; window all 0.
  - Required: `sad_min` = 640, vector (0, 0) by tie-break.
- Current block all 255; window all 0.
  - Required: `sad_min` = 16320 (no overflow), vector (0, 0).
- Two back-to-back searches with different patch positions, (3, 2) then (15, 15).
  - Required: outputs update on edge 24 and then on edge 47 with the matching vectors.
- Assert `rst` (low) at row 10 of a search.
  - Required: outputs immediately read 3FFF/0/0. A clean search after release gives its result 24 edges after release.

Source files
------------

// File: rtl/me_core_pkg.sv
// Shared sizes, the packed pixel-row type and the row-SAD helper for the
// full-search block-matching motion-estimation core.
package me_core_pkg;

    localparam int PIX_W = 8;
    localparam int BLK   = 8;
    localparam int RANGE = 16;
    localparam int WIN   = 23;
    localparam int SAD_W = 14;
    localparam int ROW_W = 11;
    localparam int CNT_W = 5;
    localparam int MV_W  = 4;

    // Element [BLK-1] holds pixel 0 (bits [63:56]).
    typedef logic [BLK-1:0][PIX_W-1:0] pixel_row_t;

    // Absolute differences are taken at 9 bits; eight of them fit in 11 bits.
    function automatic logic [ROW_W-1:0] row_sad(input pixel_row_t a, input pixel_row_t b);
        logic [PIX_W:0]   d;
        logic [ROW_W-1:0] s;
        s = '0;
        for (int i = 0; i < BLK; i++) begin
            d = {1'b0, a[i]} - {1'b0, b[i]};
            if (d[PIX_W]) begin
                d = ~d + 1'b1;
            end
            s = s + ROW_W'(d);
        end
        return s;
    endfunction

endpackage

// File: rtl/me_core_pe.sv
// One vertical-offset processing element: 16 row-SAD units feeding 16
// accumulators, one per horizontal displacement.
module me_core_pe
    import me_core_pkg::*;
#(
    parameter int K = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vld_i,
    input  logic [CNT_W-1:0]                r_i,
    input  pixel_row_t                      crt_i,
    input  pixel_row_t [RANGE-1:0]          pre_i,
    output logic [RANGE-1:0][SAD_W-1:0]     acc_o
);

    logic [RANGE-1:0][SAD_W-1:0] acc_q;
    logic [RANGE-1:0][SAD_W-1:0] acc_d;
    logic                        first;

    // The first valid row loads instead of adding, so no explicit clear is needed.
    assign first = (r_i == CNT_W'(K));

    always_comb begin
        acc_d = acc_q;
        if (vld_i) begin
            for (int x = 0; x < RANGE; x++) begin
                if (first) begin
                    acc_d[x] = SAD_W'(row_sad(crt_i, pre_i[x]));
                end else begin
                    acc_d[x] = acc_q[x] + SAD_W'(row_sad(crt_i, pre_i[x]));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/me_core.sv
// Full-search 8x8 motion estimation over a 23x23 window, one reference row per clock.
// Optional `done` strobe is enabled with macro ME_CORE_DONE_EN.
module me_core
    import me_core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        crt_frame_0,
    input  logic [63:0]        crt_frame_1,
    input  logic [63:0]        crt_frame_2,
    input  logic [63:0]        crt_frame_3,
    input  logic [63:0]        crt_frame_4,
    input  logic [63:0]        crt_frame_5,
    input  logic [63:0]        crt_frame_6,
    input  logic [63:0]        crt_frame_7,
    input  logic [63:0]        crt_frame_8,
    input  logic [63:0]        crt_frame_9,
    input  logic [63:0]        crt_frame_10,
    input  logic [63:0]        crt_frame_11,
    input  logic [63:0]        crt_frame_12,
    input  logic [63:0]        crt_frame_13,
    input  logic [63:0]        crt_frame_14,
    input  logic [63:0]        crt_frame_15,
    input  logic [63:0]        pre_frame_0,
    input  logic [63:0]        pre_frame_1,
    input  logic [63:0]        pre_frame_2,
    input  logic [63:0]        pre_frame_3,
    input  logic [63:0]        pre_frame_4,
    input  logic [63:0]        pre_frame_5,
    input  logic [63:0]        pre_frame_6,
    input  logic [63:0]        pre_frame_7,
    input  logic [63:0]        pre_frame_8,
    input  logic [63:0]        pre_frame_9,
    input  logic [63:0]        pre_frame_10,
    input  logic [63:0]        pre_frame_11,
    input  logic [63:0]        pre_frame_12,
    input  logic [63:0]        pre_frame_13,
    input  logic [63:0]        pre_frame_14,
    input  logic [63:0]        pre_frame_15,
`ifdef ME_CORE_DONE_EN
    output logic               done,
`endif
    output logic [SAD_W-1:0]   sad_min,
    output logic [MV_W-1:0]    motion_vec_x_min,
    output logic [MV_W-1:0]    motion_vec_y_min
);

    pixel_row_t [RANGE-1:0]      crt_w;
    pixel_row_t [RANGE-1:0]      pre_w;
    logic [RANGE-1:0][SAD_W-1:0] acc_w [RANGE];
    logic [RANGE-1:0]            vld;

    logic [CNT_W-1:0] r_q, r_d;
    logic             pend_q, pend_d;
    logic [SAD_W-1:0] sad_q, sad_d;
    logic [MV_W-1:0]  mvx_q, mvx_d;
    logic [MV_W-1:0]  mvy_q, mvy_d;

    assign crt_w[0]  = crt_frame_0;   assign pre_w[0]  = pre_frame_0;
    assign crt_w[1]  = crt_frame_1;   assign pre_w[1]  = pre_frame_1;
    assign crt_w[2]  = crt_frame_2;   assign pre_w[2]  = pre_frame_2;
    assign crt_w[3]  = crt_frame_3;   assign pre_w[3]  = pre_frame_3;
    assign crt_w[4]  = crt_frame_4;   assign pre_w[4]  = pre_frame_4;
    assign crt_w[5]  = crt_frame_5;   assign pre_w[5]  = pre_frame_5;
    assign crt_w[6]  = crt_frame_6;   assign pre_w[6]  = pre_frame_6;
    assign crt_w[7]  = crt_frame_7;   assign pre_w[7]  = pre_frame_7;
    assign crt_w[8]  = crt_frame_8;   assign pre_w[8]  = pre_frame_8;
    assign crt_w[9]  = crt_frame_9;   assign pre_w[9]  = pre_frame_9;
    assign crt_w[10] = crt_frame_10;  assign pre_w[10] = pre_frame_10;
    assign crt_w[11] = crt_frame_11;  assign pre_w[11] = pre_frame_11;
    assign crt_w[12] = crt_frame_12;  assign pre_w[12] = pre_frame_12;
    assign crt_w[13] = crt_frame_13;  assign pre_w[13] = pre_frame_13;
    assign crt_w[14] = crt_frame_14;  assign pre_w[14] = pre_frame_14;
    assign crt_w[15] = crt_frame_15;  assign pre_w[15] = pre_frame_15;

    // PE k sees block rows 0..7 while the reference row index runs k..k+7.
    always_comb begin
        vld = '0;
        for (int k = 0; k < RANGE; k++) begin
            vld[k] = (r_q >= CNT_W'(k)) && (r_q <= CNT_W'(k + BLK - 1));
        end
    end

    for (genvar k = 0; k < RANGE; k++) begin : g_pe
        me_core_pe #(.K(k)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .vld_i (vld[k]),
            .r_i   (r_q),
            .crt_i (crt_w[k]),
            .pre_i (pre_w),
            .acc_o (acc_w[k])
        );
    end

    assign r_d    = (r_q == CNT_W'(WIN - 1)) ? '0 : r_q + 1'b1;
    assign pend_d = (r_q == CNT_W'(WIN - 1));

    // Strict less-than in y-major order keeps the lowest y, then lowest x, on ties.
    always_comb begin
        sad_d = sad_q;
        mvx_d = mvx_q;
        mvy_d = mvy_q;
        if (pend_q) begin
            sad_d = acc_w[0][0];
            mvx_d = '0;
            mvy_d = '0;
            for (int y = 0; y < RANGE; y++) begin
                for (int x = 0; x < RANGE; x++) begin
                    if (acc_w[y][x] < sad_d) begin
                        sad_d = acc_w[y][x];
                        mvx_d = MV_W'(x);
                        mvy_d = MV_W'(y);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            pend_q <= 1'b0;
            sad_q  <= '1;
            mvx_q  <= '0;
            mvy_q  <= '0;
        end else begin
            r_q    <= r_d;
            pend_q <= pend_d;
            sad_q  <= sad_d;
            mvx_q  <= mvx_d;
            mvy_q  <= mvy_d;
        end
    end

    assign sad_min          = sad_q;
    assign motion_vec_x_min = mvx_q;
    assign motion_vec_y_min = mvy_q;

`ifdef ME_CORE_DONE_EN
    logic done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= pend_q;
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_me_core.sv
// Scoreboard bench for me_core: a window-level SAD model feeds an expected-result
// queue, and an edge-counting monitor compares whenever a result is due.
module tb_me_core;

    typedef struct {
        logic [13:0] s;
        logic [3:0]  x;
        logic [3:0]  y;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] crt_tb [16];
    logic [63:0] pre_tb [16];
    logic [13:0] sad_min;
    logic [3:0]  mvx, mvy;
`ifdef ME_CORE_DONE_EN
    logic        done;
`endif

    logic [7:0] win [23][23];
    logic [7:0] blk [8][8];
    res_t       exp_q [$];
    res_t       last_exp;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    me_core dut (
        .clk(clk), .rst(rst),
        .crt_frame_0(crt_tb[0]),   .crt_frame_1(crt_tb[1]),   .crt_frame_2(crt_tb[2]),   .crt_frame_3(crt_tb[3]),
        .crt_frame_4(crt_tb[4]),   .crt_frame_5(crt_tb[5]),   .crt_frame_6(crt_tb[6]),   .crt_frame_7(crt_tb[7]),
        .crt_frame_8(crt_tb[8]),   .crt_frame_9(crt_tb[9]),   .crt_frame_10(crt_tb[10]), .crt_frame_11(crt_tb[11]),
        .crt_frame_12(crt_tb[12]), .crt_frame_13(crt_tb[13]), .crt_frame_14(crt_tb[14]), .crt_frame_15(crt_tb[15]),
        .pre_frame_0(pre_tb[0]),   .pre_frame_1(pre_tb[1]),   .pre_frame_2(pre_tb[2]),   .pre_frame_3(pre_tb[3]),
        .pre_frame_4(pre_tb[4]),   .pre_frame_5(pre_tb[5]),   .pre_frame_6(pre_tb[6]),   .pre_frame_7(pre_tb[7]),
        .pre_frame_8(pre_tb[8]),   .pre_frame_9(pre_tb[9]),   .pre_frame_10(pre_tb[10]), .pre_frame_11(pre_tb[11]),
        .pre_frame_12(pre_tb[12]), .pre_frame_13(pre_tb[13]), .pre_frame_14(pre_tb[14]), .pre_frame_15(pre_tb[15]),
`ifdef ME_CORE_DONE_EN
        .done(done),
`endif
        .sad_min(sad_min),
        .motion_vec_x_min(mvx),
        .motion_vec_y_min(mvy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: exhaustive SAD of the block against every window position.
    function automatic res_t model();
        res_t r;
        int   s;
        r.s = 14'h3FFF; r.x = 0; r.y = 0;
        for (int dy = 0; dy < 16; dy++) begin
            for (int dx = 0; dx < 16; dx++) begin
                s = 0;
                for (int j = 0; j < 8; j++)
                    for (int i = 0; i < 8; i++)
                        s += (blk[j][i] > win[dy+j][dx+i]) ? int'(blk[j][i]) - int'(win[dy+j][dx+i])
                                                          : int'(win[dy+j][dx+i]) - int'(blk[j][i]);
                if ((dy == 0 && dx == 0) || s < int'(r.s)) begin
                    r.s = 14'(s); r.x = 4'(dx); r.y = 4'(dy);
                end
            end
        end
        return r;
    endfunction

    task automatic drive_row(input int r);
        logic [63:0] v;
        for (int x = 0; x < 16; x++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[55:0], win[r][x+i]};
            pre_tb[x] = v;
        end
        for (int k = 0; k < 16; k++) begin
            if (r >= k && r <= k + 7) begin
                v = '0;
                for (int i = 0; i < 8; i++) v = {v[55:0], blk[r-k][i]};
                crt_tb[k] = v;
            end else begin
                crt_tb[k] = {$urandom, $urandom};
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after row 22 is sampled.
    task automatic run_search();
        exp_q.push_back(model());
        for (int r = 0; r < 23; r++) begin
            drive_row(r);
            @(negedge clk);
        end
    endtask

    task automatic fill(input int wv, input int bv);
        for (int j = 0; j < 23; j++) for (int i = 0; i < 23; i++) win[j][i] = 8'(wv);
        for (int j = 0; j < 8; j++)  for (int i = 0; i < 8; i++)  blk[j][i] = 8'(bv);
    endtask

    task automatic patch(input int px, input int py, input int v);
        for (int j = 0; j < 8; j++) for (int i = 0; i < 8; i++) win[py+j][px+i] = 8'(v);
    endtask

    // Monitor: results are due 24 edges after release and every 23 thereafter.
    initial begin
        int   ecnt;
        res_t e;
        ecnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                ecnt = 0;
                last_exp.s = 14'h3FFF; last_exp.x = 0; last_exp.y = 0;
            end else begin
                ecnt++;
                if (ecnt >= 24 && (ecnt - 24) % 23 == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sad_min", 32'(sad_min), 32'(e.s));
                        chk("mv_x", 32'(mvx), 32'(e.x));
                        chk("mv_y", 32'(mvy), 32'(e.y));
`ifdef ME_CORE_DONE_EN
                        chk("done_pulse", 32'(done), 1);
`endif
                        last_exp = e;
                    end
                end else if (ecnt >= 23 && (ecnt - 23) % 23 == 0) begin
                    chk("hold_sad", 32'(sad_min), 32'(last_exp.s));
                    chk("hold_mv_x", 32'(mvx), 32'(last_exp.x));
                    chk("hold_mv_y", 32'(mvy), 32'(last_exp.y));
`ifdef ME_CORE_DONE_EN
                    chk("done_idle", 32'(done), 0);
`endif
                end
            end
        end
    end

    initial begin
        int px, py;
        for (int k = 0; k < 16; k++) begin crt_tb[k] = '0; pre_tb[k] = '0; end
        fill(0, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_sad", 32'(sad_min), 32'h3FFF);
        chk("rst_mv_x", 32'(mvx), 0);
        chk("rst_mv_y", 32'(mvy), 0);
        @(negedge clk);
        rst = 1'b1;

        fill(0, 0);
        for (int j = 0; j < 23; j++) win[j][22] = 8'd1;
        run_search();
        fill(0, 200); patch(5, 9, 200);   run_search();
        fill(0, 10);                       run_search();
        fill(0, 255);                      run_search();
        fill(0, 77);  patch(3, 2, 77);     run_search();
        fill(0, 77);  patch(15, 15, 77);   run_search();

        // Abort a search at row 10: outputs must clear at once.
        fill(0, 50); patch(7, 4, 50);
        exp_q.push_back(model());
        for (int r = 0; r < 10; r++) begin
            drive_row(r);
            @(negedge clk);
        end
        drive_row(10);
        rst = 1'b0;
        #1;
        chk("abort_sad", 32'(sad_min), 32'h3FFF);
        chk("abort_mv_x", 32'(mvx), 0);
        chk("abort_mv_y", 32'(mvy), 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        fill(0, 90); patch(11, 6, 90);     run_search();

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 23; j++) for (int i = 0; i < 23; i++) win[j][i] = 8'($urandom_range(0, 255));
            if (t < 3) begin
                for (int j = 0; j < 8; j++) for (int i = 0; i < 8; i++) blk[j][i] = 8'($urandom_range(0, 255));
            end else begin
                px = $urandom_range(0, 15);
                py = $urandom_range(0, 15);
                for (int j = 0; j < 8; j++) for (int i = 0; i < 8; i++) blk[j][i] = win[py+j][px+i];
            end
            run_search();
        end
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 23; j++) for (int i = 0; i < 23; i++) win[j][i] = 8'($urandom_range(0, 2));
            for (int j = 0; j < 8; j++)  for (int i = 0; i < 8; i++)  blk[j][i] = 8'($urandom_range(0, 2));
            run_search();
        end

        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            drive_row(c % 23);
            @(negedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
